load_store_unit: RTL

//  Sits between the execute stage and data_memory and sizes every data access. Decodes RV64 load/store

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_lane_fmt.sv | 36 +++
 rtl/load_store_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// access-size decode and funct3 legality.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } state_t;

    // log2 of the access size in bytes
    function automatic logic [1:0] size_log2(input logic [2:0] f3);
        return f3[1:0];
    endfunction

    function automatic logic funct3_ok(input logic is_store, input logic [2:0] f3);
        return is_store ? !f3[2] : (f3 != 3'b111);
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Load extract/extend and store byte merge into the old doubleword.
// Purely combinational.
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [63:0] mem_data,
    input  logic [63:0] store_data,
    output logic [63:0] load_data,
    output logic [63:0] merge_data
);

    always_comb begin
        load_data  = mem_data;
        merge_data = store_data;
        unique case (funct3)
            F3_B: begin
                load_data  = {{56{mem_data[7]}}, mem_data[7:0]};
                merge_data = {mem_data[63:8], store_data[7:0]};
            end
            F3_H: begin
                load_data  = {{48{mem_data[15]}}, mem_data[15:0]};
                merge_data = {mem_data[63:16], store_data[15:0]};
            end
            F3_W: begin
                load_data  = {{32{mem_data[31]}}, mem_data[31:0]};
                merge_data = {mem_data[63:32], store_data[31:0]};
            end
            F3_BU: load_data = {56'd0, mem_data[7:0]};
            F3_HU: load_data = {48'd0, mem_data[15:0]};
            F3_WU: load_data = {32'd0, mem_data[31:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sized RV64 load/store engine in front of an 8-byte-write data memory.
// Define MISALIGN_TRAP_EN to fault accesses not aligned to their size.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE = 8192,
    parameter int ADDR_W   = 13,
    parameter int XLEN     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [XLEN-1:0]   mem_write_data,
    input  logic [XLEN-1:0]   mem_read_data
);

    state_t            state;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   merge_data;
    logic              accept;
    logic              range_err;
    logic              f3_err;
    logic              align_err;
    logic              req_err;

    assign accept    = req_valid && req_ready;
    assign range_err = req_addr > XLEN'(MEM_SIZE - 8);
    assign f3_err    = !funct3_ok(req_is_store, req_funct3);

`ifdef MISALIGN_TRAP_EN
    // mask = size-1; for a doubleword 1<<3 wraps to 0 in 3 bits, giving 3'b111
    assign align_err = |(req_addr[2:0]
                       & ((3'b001 << size_log2(req_funct3)) - 3'b001));
`else
    assign align_err = 1'b0;
`endif

    assign req_err = range_err || f3_err || align_err;

    assign req_ready      = (state == S_IDLE);
    assign resp_valid     = (state == S_RESP);
    assign mem_read       = (state == S_LOAD) || (state == S_RMW_RD);
    assign mem_write      = (state == S_WRITE);
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;

    lsu_lane_fmt u_fmt (
        .funct3     (funct3_q),
        .mem_data   (mem_read_data),
        .store_data (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        funct3_q   <= req_funct3;
                        addr_q     <= req_addr[ADDR_W-1:0];
                        wdata_q    <= req_wdata;
                        resp_rdata <= '0;
                        resp_err   <= req_err;
                        if (req_err)
                            state <= S_RESP;
                        else if (!req_is_store)
                            state <= S_LOAD;
                        else if (req_funct3 == F3_D)
                            state <= S_WRITE;
                        else
                            state <= S_RMW_RD;
                    end
                end
                S_LOAD: begin
                    resp_rdata <= load_data;
                    state      <= S_RESP;
                end
                S_RMW_RD: begin
                    wdata_q <= merge_data;
                    state   <= S_WRITE;
                end
                S_WRITE: state <= S_RESP;
                S_RESP: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
